warp_barrier_unit: RTL and testbench

Per-core warp barrier unit that consumes the barrier request decoded by the SFU/warp-control stage (valid, id, is_global, size_m1, plus the issuing warp id). It gathers arriving warps per barrier id and holds them stalled. It then releases them to the warp scheduler as one release mask. Global barriers are optionally escalated to the cluster barrier arbiter.

---
 rtl/warp_barrier_pkg.sv | 37 +++
 rtl/warp_barrier_entry.sv | 89 ++++++++
 rtl/warp_barrier_unit.sv | 128 ++++++++++++
 tb/tb_warp_barrier_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/warp_barrier_pkg.sv
// Shared types and widths for the warp barrier unit: barrier request, entry
// record and entry state encoding.
package warp_barrier_pkg;

  localparam int NUM_WARPS    = 4;
  localparam int NUM_BARRIERS = 4;
  localparam int NW_WIDTH     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

  typedef enum logic [1:0] {
    WBAR_IDLE   = 2'd0,
    WBAR_GATHER = 2'd1,
    WBAR_REQ    = 2'd2,
    WBAR_WAIT   = 2'd3
  } wbar_state_e;

  typedef struct packed {
    wbar_state_e           state;
    logic [NW_WIDTH-1:0]   count;
    logic [NW_WIDTH-1:0]   size_m1;
    logic [NUM_WARPS-1:0]  wmask;
  } wbar_entry_t;

  typedef struct packed {
    logic                 valid;
    logic [NW_WIDTH-1:0]  wid;
    logic [NB_WIDTH-1:0]  id;
    logic                 is_global;
    logic [NW_WIDTH-1:0]  size_m1;
  } barrier_t;

  function automatic logic [NUM_WARPS-1:0] wid_bit(input logic [NW_WIDTH-1:0] wid);
    wid_bit      = '0;
    wid_bit[wid] = 1'b1;
  endfunction

endpackage

// File: rtl/warp_barrier_entry.sv
// One barrier id: gathers arriving warps, completes locally or escalates to the
// cluster arbiter (REQ -> WAIT) and reports the warps to release or stall.
module warp_barrier_entry
  import warp_barrier_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arrive,
  input  logic [NW_WIDTH-1:0]  wid,
  input  logic [NW_WIDTH-1:0]  size_m1,
  input  logic                 is_global,
  input  logic                 req_accept,
  input  logic                 rsp_hit,
  output wbar_state_e          state,
  output logic [NUM_WARPS-1:0] rel_mask,
  output logic [NUM_WARPS-1:0] stall_set
);

  wbar_entry_t          q;
  wbar_entry_t          nxt;
  logic [NUM_WARPS-1:0] wbit;
  logic                 done;

  assign wbit  = wid_bit(wid);
  assign state = q.state;

  // An arrival completes when the prior arrivals already equal size_m1; the
  // first arrival has no latched size yet, so the request's own field is used.
  always_comb begin
    done = 1'b0;
    if (arrive) begin
      if (q.state == WBAR_IDLE) done = (size_m1 == '0);
      else                      done = (q.count == q.size_m1);
    end
  end

  always_comb begin
    nxt       = q;
    rel_mask  = '0;
    stall_set = '0;
    case (q.state)
      WBAR_IDLE, WBAR_GATHER: begin
        if (arrive) begin
          if (done && is_global) begin
            nxt.state = WBAR_REQ;
            nxt.count = '0;
            nxt.wmask = q.wmask | wbit;
            stall_set = wbit;
          end else if (done) begin
            nxt.state = WBAR_IDLE;
            nxt.count = '0;
            nxt.wmask = '0;
            rel_mask  = q.wmask | wbit;
          end else begin
            nxt.state = WBAR_GATHER;
            nxt.count = q.count + NW_WIDTH'(1);
            nxt.wmask = q.wmask | wbit;
            stall_set = wbit;
            if (q.state == WBAR_IDLE) nxt.size_m1 = size_m1;
          end
        end
      end
      WBAR_REQ: begin
        if (req_accept) nxt.state = WBAR_WAIT;
      end
      WBAR_WAIT: begin
        if (rsp_hit) begin
          nxt.state = WBAR_IDLE;
          nxt.wmask = '0;
          rel_mask  = q.wmask;
        end
      end
      default: nxt = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= nxt;
  end

  a_arrive_state: assert property (@(posedge clk) disable iff (reset)
    arrive |-> (q.state == WBAR_IDLE || q.state == WBAR_GATHER));
  a_size_match: assert property (@(posedge clk) disable iff (reset)
    (arrive && q.state == WBAR_GATHER) |-> (size_m1 == q.size_m1));
  a_rsp_wait: assert property (@(posedge clk) disable iff (reset)
    rsp_hit |-> (q.state == WBAR_WAIT));

endmodule

// File: rtl/warp_barrier_unit.sv
// Per-core warp barrier unit: decodes arrivals to per-id entries, ORs releases
// into one pulse and arbitrates global escalation (WBAR_GLOBAL_EN).
module warp_barrier_unit
  import warp_barrier_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bar_valid,
  input  logic [NW_WIDTH-1:0]  bar_wid,
  input  logic [NB_WIDTH-1:0]  bar_id,
  input  logic                 bar_is_global,
  input  logic [NW_WIDTH-1:0]  bar_size_m1,
  output logic [NUM_WARPS-1:0] stalled_wmask,
  output logic                 release_valid,
  output logic [NUM_WARPS-1:0] release_wmask,
  output logic                 gbar_req_valid,
  output logic [NB_WIDTH-1:0]  gbar_req_id,
  input  logic                 gbar_req_ready,
  input  logic                 gbar_rsp_valid,
  input  logic [NB_WIDTH-1:0]  gbar_rsp_id
);

  barrier_t                               req;
  logic                                   is_global_eff;
  logic [NUM_BARRIERS-1:0]                req_accept;
  logic [NUM_BARRIERS-1:0]                rsp_hit;
  wbar_state_e [NUM_BARRIERS-1:0]         entry_state;
  logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] entry_rel;
  logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] entry_set;
  logic [NUM_WARPS-1:0]                   rel_all;
  logic [NUM_WARPS-1:0]                   set_all;

  assign req = '{valid: bar_valid, wid: bar_wid, id: bar_id,
                 is_global: bar_is_global, size_m1: bar_size_m1};

  for (genvar gi = 0; gi < NUM_BARRIERS; gi++) begin : g_entry
    warp_barrier_entry u_entry (
      .clk        (clk),
      .reset      (reset),
      .arrive     (req.valid && (req.id == NB_WIDTH'(gi))),
      .wid        (req.wid),
      .size_m1    (req.size_m1),
      .is_global  (is_global_eff),
      .req_accept (req_accept[gi]),
      .rsp_hit    (rsp_hit[gi]),
      .state      (entry_state[gi]),
      .rel_mask   (entry_rel[gi]),
      .stall_set  (entry_set[gi])
    );
  end

  always_comb begin
    rel_all = '0;
    set_all = '0;
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      rel_all = rel_all | entry_rel[i];
      set_all = set_all | entry_set[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stalled_wmask <= '0;
      release_valid <= 1'b0;
      release_wmask <= '0;
    end else begin
      stalled_wmask <= (stalled_wmask | set_all) & ~rel_all;
      release_valid <= |rel_all;
      release_wmask <= rel_all;
    end
  end

  a_no_restall: assert property (@(posedge clk) disable iff (reset)
    req.valid |-> !stalled_wmask[req.wid]);

`ifdef WBAR_GLOBAL_EN
  logic                    hold_q;
  logic [NB_WIDTH-1:0]     hold_id_q;
  logic [NB_WIDTH-1:0]     pick_id;
  logic                    pick_found;
  logic [NUM_BARRIERS-1:0] req_pending;

  always_comb begin
    pick_id    = '0;
    pick_found = 1'b0;
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      req_pending[i] = (entry_state[i] == WBAR_REQ);
      if (req_pending[i] && !pick_found) begin
        pick_id    = NB_WIDTH'(i);
        pick_found = 1'b1;
      end
    end
  end

  // A stalled request keeps its id even if a lower id becomes pending meanwhile.
  assign gbar_req_valid = hold_q | pick_found;
  assign gbar_req_id    = hold_q ? hold_id_q : pick_id;
  assign is_global_eff  = req.is_global;

  always_comb begin
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      req_accept[i] = gbar_req_valid && gbar_req_ready && (gbar_req_id == NB_WIDTH'(i));
      rsp_hit[i]    = gbar_rsp_valid && (gbar_rsp_id == NB_WIDTH'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q    <= 1'b0;
      hold_id_q <= '0;
    end else begin
      hold_q    <= gbar_req_valid && !gbar_req_ready;
      hold_id_q <= gbar_req_id;
    end
  end
`else
  logic unused_global;

  assign gbar_req_valid = 1'b0;
  assign gbar_req_id    = '0;
  assign is_global_eff  = 1'b0;
  assign req_accept     = '0;
  assign rsp_hit        = '0;
  assign unused_global  = ^{req.is_global, gbar_req_ready, gbar_rsp_valid,
                            gbar_rsp_id, entry_state};
`endif

endmodule

// File: tb/tb_warp_barrier_unit.sv
// Directed bench for warp_barrier_unit; global-barrier cases run when the
// bench is built with WBAR_GLOBAL_EN.
module tb_warp_barrier_unit;
  import warp_barrier_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 bar_valid = 1'b0;
  logic [NW_WIDTH-1:0]  bar_wid = '0;
  logic [NB_WIDTH-1:0]  bar_id = '0;
  logic                 bar_is_global = 1'b0;
  logic [NW_WIDTH-1:0]  bar_size_m1 = '0;
  logic [NUM_WARPS-1:0] stalled_wmask;
  logic                 release_valid;
  logic [NUM_WARPS-1:0] release_wmask;
  logic                 gbar_req_valid;
  logic [NB_WIDTH-1:0]  gbar_req_id;
  logic                 gbar_req_ready = 1'b0;
  logic                 gbar_rsp_valid = 1'b0;
  logic [NB_WIDTH-1:0]  gbar_rsp_id = '0;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  warp_barrier_unit dut (
    .clk            (clk),
    .reset          (reset),
    .bar_valid      (bar_valid),
    .bar_wid        (bar_wid),
    .bar_id         (bar_id),
    .bar_is_global  (bar_is_global),
    .bar_size_m1    (bar_size_m1),
    .stalled_wmask  (stalled_wmask),
    .release_valid  (release_valid),
    .release_wmask  (release_wmask),
    .gbar_req_valid (gbar_req_valid),
    .gbar_req_id    (gbar_req_id),
    .gbar_req_ready (gbar_req_ready),
    .gbar_rsp_valid (gbar_rsp_valid),
    .gbar_rsp_id    (gbar_rsp_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive one arrival for one cycle; outputs are then sampled 1 time unit after the edge
  task automatic arrive(input int wid, input int id, input int size_m1, input bit glob);
    bar_valid     = 1'b1;
    bar_wid       = NW_WIDTH'(wid);
    bar_id        = NB_WIDTH'(id);
    bar_size_m1   = NW_WIDTH'(size_m1);
    bar_is_global = glob;
    step();
    bar_valid     = 1'b0;
    bar_is_global = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [3:0] stl, input logic rv,
                           input logic [3:0] rm);
    check({tag, "_stalled"}, 32'(stalled_wmask), 32'(stl));
    check({tag, "_rel_v"},   32'(release_valid), 32'(rv));
    check({tag, "_rel_m"},   32'(release_wmask), 32'(rm));
  endtask

  initial begin
    step();
    step();
    check_out("reset", 4'b0000, 1'b0, 4'b0000);
    check("reset_greq_v", 32'(gbar_req_valid), 32'd0);
    check("reset_greq_id", 32'(gbar_req_id), 32'd0);
    reset = 1'b0;
    step();

    // id 1 gathers warps 0, 2, 3
    arrive(0, 1, 2, 1'b0);
    check_out("g3_a0", 4'b0001, 1'b0, 4'b0000);
    arrive(2, 1, 2, 1'b0);
    check_out("g3_a2", 4'b0101, 1'b0, 4'b0000);
    arrive(3, 1, 2, 1'b0);
    check_out("g3_rel", 4'b0000, 1'b1, 4'b1101);
    step();
    check_out("g3_after", 4'b0000, 1'b0, 4'b0000);

    // single participant barrier
    arrive(3, 0, 0, 1'b0);
    check_out("single", 4'b0000, 1'b1, 4'b1000);
    step();
    check_out("single_after", 4'b0000, 1'b0, 4'b0000);

    // re-arrival on id 1 during its release cycle restarts at count 1
    arrive(0, 1, 1, 1'b0);
    arrive(1, 1, 1, 1'b0);
    check_out("rst1_rel", 4'b0000, 1'b1, 4'b0011);
    arrive(0, 1, 1, 1'b0);
    check_out("rst1_again", 4'b0001, 1'b0, 4'b0000);
    arrive(1, 1, 1, 1'b0);
    check_out("rst1_rel2", 4'b0000, 1'b1, 4'b0011);

    // interleaved ids 0 and 2
    arrive(0, 0, 1, 1'b0);
    arrive(2, 2, 1, 1'b0);
    check_out("mix_two", 4'b0101, 1'b0, 4'b0000);
    arrive(1, 0, 1, 1'b0);
    check_out("mix_id0", 4'b0100, 1'b1, 4'b0011);
    arrive(3, 2, 1, 1'b0);
    check_out("mix_id2", 4'b0000, 1'b1, 4'b1100);
    step();

    // reset mid-barrier drops state; fresh arrival counts from 1
    arrive(0, 3, 3, 1'b0);
    arrive(1, 3, 3, 1'b0);
    check_out("mid_pre", 4'b0011, 1'b0, 4'b0000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_out("mid_reset", 4'b0000, 1'b0, 4'b0000);
    check("mid_greq_v", 32'(gbar_req_valid), 32'd0);
    arrive(2, 3, 1, 1'b0);
    check_out("mid_fresh", 4'b0100, 1'b0, 4'b0000);
    arrive(3, 3, 1, 1'b0);
    check_out("mid_rel", 4'b0000, 1'b1, 4'b1100);
    step();

`ifdef WBAR_GLOBAL_EN
    // global id 2: escalate, hold request while not ready, release on response
    arrive(0, 2, 1, 1'b1);
    check_out("gl_a0", 4'b0001, 1'b0, 4'b0000);
    arrive(1, 2, 1, 1'b1);
    check_out("gl_a1", 4'b0011, 1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      check("gl_req_v", 32'(gbar_req_valid), 32'd1);
      check("gl_req_id", 32'(gbar_req_id), 32'd2);
      step();
    end
    gbar_req_ready = 1'b1;
    step();
    gbar_req_ready = 1'b0;
    check("gl_req_done", 32'(gbar_req_valid), 32'd0);
    check_out("gl_wait", 4'b0011, 1'b0, 4'b0000);
    gbar_rsp_valid = 1'b1;
    gbar_rsp_id    = 2'd2;
    step();
    gbar_rsp_valid = 1'b0;
    check_out("gl_rel", 4'b0000, 1'b1, 4'b0011);
    step();

    // local completion on id 0 coincides with global response for id 2
    arrive(2, 2, 0, 1'b1);
    check_out("co_g", 4'b0100, 1'b0, 4'b0000);
    check("co_req_id", 32'(gbar_req_id), 32'd2);
    gbar_req_ready = 1'b1;
    step();
    gbar_req_ready = 1'b0;
    arrive(0, 0, 1, 1'b0);
    gbar_rsp_valid = 1'b1;
    gbar_rsp_id    = 2'd2;
    arrive(1, 0, 1, 1'b0);
    gbar_rsp_valid = 1'b0;
    check_out("co_rel", 4'b0000, 1'b1, 4'b0111);
    step();
    check_out("co_after", 4'b0000, 1'b0, 4'b0000);
`else
    // global flag ignored: completes locally and never escalates
    arrive(0, 2, 1, 1'b1);
    check("ng_req_v0", 32'(gbar_req_valid), 32'd0);
    arrive(1, 2, 1, 1'b1);
    check_out("ng_rel", 4'b0000, 1'b1, 4'b0011);
    check("ng_req_v1", 32'(gbar_req_valid), 32'd0);
    step();
    check("ng_req_v2", 32'(gbar_req_valid), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
